// File: rtl/mppt_pkg.sv
// Shared types and default widths for the perturb-and-observe MPPT tracker.
package mppt_pkg;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_WAIT_SAMPLE = 3'd1,
      ST_MULT        = 3'd2,
      ST_COMPARE     = 3'd3,
      ST_SETTLE      = 3'd4
   } mppt_state_e;

   localparam int unsigned DATA_W_DEF  = 8;
   localparam int unsigned DUTY_W_DEF  = 8;
   localparam int unsigned POWER_W_DEF = 2 * DATA_W_DEF;

   // Bits needed to hold values 0 .. n-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 32'd2) ? 32'd1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mppt_pwm_gen.sv
// Free-running PWM generator for the duty word; only present when MPPT_PWM_EN is defined.
`ifdef MPPT_PWM_EN
module mppt_pwm_gen
   import mppt_pkg::*;
#(
   parameter int unsigned DUTY_W = DUTY_W_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [DUTY_W-1:0] i_duty,
   output logic              o_pwm
);

   logic [DUTY_W-1:0] r_cnt;
   logic              r_pwm;

   // Counter wraps naturally at 2^DUTY_W-1 and runs regardless of tracker enable.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= {DUTY_W{1'b0}};
         r_pwm <= 1'b0;
      end else begin
         r_cnt <= r_cnt + DUTY_W'(1);
         r_pwm <= (r_cnt < i_duty);
      end
   end

   assign o_pwm = r_pwm;

endmodule
`endif

// File: rtl/mppt_po_tracker.sv
// Perturb-and-observe MPPT tracker: samples V/I, computes P, steps a clamped duty word.
// Optional PWM drive is built when MPPT_PWM_EN is defined; otherwise o_pwm_out is tied low.
module mppt_po_tracker
   import mppt_pkg::*;
#(
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned DUTY_W     = DUTY_W_DEF,
   parameter int unsigned DUTY_INIT  = 128,
   parameter int unsigned DUTY_MIN   = 16,
   parameter int unsigned DUTY_MAX   = 240,
   parameter int unsigned STEP       = 4,
   parameter int unsigned SETTLE_CYC = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_ena,
   input  logic                  i_sample_valid,
   input  logic [DATA_W-1:0]     i_v_in,
   input  logic [DATA_W-1:0]     i_i_in,
   output logic                  o_sample_ready,
   output logic [DUTY_W-1:0]     o_duty,
   output logic                  o_duty_valid,
   output logic                  o_dir,
   output logic [2*DATA_W-1:0]   o_power_out,
   output logic                  o_pwm_out
);

   localparam int unsigned POWER_W = 2 * DATA_W;
   localparam int unsigned DSUM_W  = DUTY_W + 1;
   localparam int unsigned CNT_W   = cnt_width(SETTLE_CYC);

   mppt_state_e          r_state;
   mppt_state_e          w_state_nxt;
   logic [DATA_W-1:0]    r_v;
   logic [DATA_W-1:0]    r_i;
   logic [POWER_W-1:0]   r_power;
   logic [POWER_W-1:0]   r_prev;
   logic [DUTY_W-1:0]    r_duty;
   logic [DUTY_W-1:0]    w_duty_nxt;
   logic                 r_dir;
   logic                 w_dir_nxt;
   logic                 r_first;
   logic                 r_duty_valid;
   logic [CNT_W-1:0]     r_settle_cnt;
   logic                 w_do_step;
   logic                 w_step_dir;
   logic [DSUM_W-1:0]    w_up;
   logic [DSUM_W-1:0]    w_dn;

   // Dropping enable forces IDLE from any state; otherwise walk the sample/compute/settle loop.
   always_comb begin
      w_state_nxt = r_state;
      if (!i_ena) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:        w_state_nxt = ST_WAIT_SAMPLE;
            ST_WAIT_SAMPLE: begin
               if (i_sample_valid) begin
                  w_state_nxt = ST_MULT;
               end else begin
                  w_state_nxt = ST_WAIT_SAMPLE;
               end
            end
            ST_MULT:        w_state_nxt = ST_COMPARE;
            ST_COMPARE:     w_state_nxt = ST_SETTLE;
            ST_SETTLE: begin
               if (r_settle_cnt == {CNT_W{1'b0}}) begin
                  w_state_nxt = ST_WAIT_SAMPLE;
               end else begin
                  w_state_nxt = ST_SETTLE;
               end
            end
            default:        w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Perturb-and-observe decision: the first sample has no history, equal power holds still.
   always_comb begin
      w_do_step  = 1'b0;
      w_step_dir = r_dir;
      if (r_first) begin
         w_do_step  = 1'b1;
         w_step_dir = r_dir;
      end else if (r_power > r_prev) begin
         w_do_step  = 1'b1;
         w_step_dir = r_dir;
      end else if (r_power < r_prev) begin
         w_do_step  = 1'b1;
         w_step_dir = ~r_dir;
      end else begin
         w_do_step  = 1'b0;
         w_step_dir = r_dir;
      end
   end

   // One extra bit so an overshoot above DUTY_MAX or a wrap below zero is visible.
   assign w_up = {1'b0, r_duty} + DSUM_W'(STEP);
   assign w_dn = {1'b0, r_duty} - DSUM_W'(STEP);

   // Saturate into [DUTY_MIN, DUTY_MAX]; hitting a rail bounces the direction.
   always_comb begin
      w_duty_nxt = r_duty;
      w_dir_nxt  = w_step_dir;
      if (!w_do_step) begin
         w_duty_nxt = r_duty;
         w_dir_nxt  = w_step_dir;
      end else if (w_step_dir) begin
         if (w_up > DSUM_W'(DUTY_MAX)) begin
            w_duty_nxt = DUTY_W'(DUTY_MAX);
            w_dir_nxt  = 1'b0;
         end else begin
            w_duty_nxt = w_up[DUTY_W-1:0];
            w_dir_nxt  = 1'b1;
         end
      end else begin
         if (w_dn[DUTY_W] || (w_dn < DSUM_W'(DUTY_MIN))) begin
            w_duty_nxt = DUTY_W'(DUTY_MIN);
            w_dir_nxt  = 1'b1;
         end else begin
            w_duty_nxt = w_dn[DUTY_W-1:0];
            w_dir_nxt  = 1'b0;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Datapath registers; with enable low everything holds and no pulse is produced.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_v          <= {DATA_W{1'b0}};
         r_i          <= {DATA_W{1'b0}};
         r_power      <= {POWER_W{1'b0}};
         r_prev       <= {POWER_W{1'b0}};
         r_duty       <= DUTY_W'(DUTY_INIT);
         r_dir        <= 1'b1;
         r_first      <= 1'b1;
         r_duty_valid <= 1'b0;
         r_settle_cnt <= {CNT_W{1'b0}};
      end else begin
         r_duty_valid <= 1'b0;
         if (i_ena) begin
            case (r_state)
               ST_WAIT_SAMPLE: begin
                  if (i_sample_valid) begin
                     r_v <= i_v_in;
                     r_i <= i_i_in;
                  end
               end
               ST_MULT: begin
                  r_power <= POWER_W'(r_v) * POWER_W'(r_i);
               end
               ST_COMPARE: begin
                  r_duty       <= w_duty_nxt;
                  r_dir        <= w_dir_nxt;
                  r_prev       <= r_power;
                  r_first      <= 1'b0;
                  r_duty_valid <= 1'b1;
                  r_settle_cnt <= CNT_W'(SETTLE_CYC - 1);
               end
               ST_SETTLE: begin
                  if (r_settle_cnt != {CNT_W{1'b0}}) begin
                     r_settle_cnt <= r_settle_cnt - CNT_W'(1);
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign o_sample_ready = (r_state == ST_WAIT_SAMPLE) && i_ena;
   assign o_duty         = r_duty;
   assign o_duty_valid   = r_duty_valid;
   assign o_dir          = r_dir;
   assign o_power_out    = r_power;

`ifdef MPPT_PWM_EN
   logic w_pwm;

   mppt_pwm_gen #(
      .DUTY_W (DUTY_W)
   ) u_pwm (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_duty  (r_duty),
      .o_pwm   (w_pwm)
   );

   assign o_pwm_out = w_pwm;
`else
   assign o_pwm_out = 1'b0;
`endif

endmodule

// File: doc/mppt_po_tracker.md
Name: mppt_po_tracker

Overview:
- Parametrised perturb-and-observe maximum-power-point tracker for the renewable energy converter datapath.
- Accepts voltage/current sample pairs over a valid/ready handshake and computes power P = V*I.
- Compares P against the previous sample and steps a converter duty-cycle word up or down.
- Sits between the sample front end (ui_in/uio_in style inputs) and the converter drive output.

Parameters:
- DATA_W, 8, width of the v_in and i_in samples.
- DUTY_W, 8, width of the duty word.
- DUTY_INIT, 128, duty value after reset.
- DUTY_MIN, 16, lower duty clamp, inclusive.
- DUTY_MAX, 240, upper duty clamp, inclusive.
- STEP, 4, duty perturbation per update.
- SETTLE_CYC, 16, cycles to wait after each duty update before the next sample is accepted; must be ≥1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  tracker enable.
- sample_valid  in  1  v_in/i_in valid.
- v_in  in  DATA_W  voltage sample, unsigned.
- i_in  in  DATA_W  current sample, unsigned.
- sample_ready  out  1  tracker can accept a sample.
- duty  out  DUTY_W  current duty command.
- duty_valid  out  1  one-cycle pulse when duty has been re-evaluated.
- dir  out  1  perturbation direction: 1 = increasing, 0 = decreasing.
- power_out  out  2*DATA_W  last computed power.
- pwm_out  out  1  PWM drive (see Optional Feature).

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, duty=DUTY_INIT, dir=1, power_out=0, prev power=0, first-sample flag=1, sample_ready=0, duty_valid=0, settle counter=0, pwm_out=0.
- FSM states: IDLE, WAIT_SAMPLE, MULT, COMPARE, SETTLE.
  - IDLE: go to WAIT_SAMPLE when ena=1.
  - WAIT_SAMPLE: sample_ready=1 (combinational from state). Accept on sample_valid&&sample_ready: register v_in and i_in, go to MULT.
  - MULT: power_out <= v*i, full 2*DATA_W unsigned, no truncation. Go to COMPARE.
  - COMPARE: decide, update duty, pulse duty_valid for one cycle, load the settle counter with SETTLE_CYC-1, go to SETTLE.
  - SETTLE: decrement the counter; at 0 go to WAIT_SAMPLE.
- Latency: sample accepted at edge T; power_out valid after T+1; duty and duty_valid update at T+2. The next sample_ready rises SETTLE_CYC cycles after the duty update.
- COMPARE decision:
  - First sample after reset: no comparison; step duty in dir, clear the first-sample flag.
  - P > prev: keep dir, step.
  - P < prev: invert dir, step in the new dir.
  - P == prev: duty unchanged, dir unchanged; duty_valid still pulses.
  - In all cases prev <= P.
- Step arithmetic: compute in DUTY_W+1 bits, then saturate to [DUTY_MIN, DUTY_MAX]. If the result clamps, duty = the limit and dir inverts in the same cycle.
- ena=0 in any state: return to IDLE on the next edge. duty, dir, prev and the first-sample flag are held; no duty_valid pulse; sample_ready=0.
- sample_valid while not ready is ignored; there is no buffering.
- rst_n low mid-operation (any state): all registers return to reset values immediately, and pending work is discarded.

Optional Feature:
- Macro MPPT_PWM_EN.
- Defined: instantiates a free-running DUTY_W-bit counter; pwm_out = (counter < duty). The counter resets to 0, wraps at 2^DUTY_W-1, and runs regardless of ena.
- Undefined: no counter; pwm_out tied to 0.

Decomposition:
- Package mppt_pkg holds the FSM state enum (3-bit encoding) and localparam widths derived from DATA_W and DUTY_W.
- One sub-module, mppt_pwm_gen (counter + comparator), instantiated only under MPPT_PWM_EN.
- Multiplier, compare and clamp stay in the top.

Test Plan:
1. Reset with ena=1 -> duty=128, dir=1, power_out=0; sample_ready=1 two cycles after rst_n rises (IDLE→WAIT_SAMPLE).
2. Sample v=150, i=85 -> power_out=12750 after T+1; duty=132 with a duty_valid pulse at T+2; sample_ready=0 for 16 cycles.
3. Then v=150, i=90 (13500) -> duty=136, dir=1. Then v=45, i=255 (11475) -> dir=0, duty=132.
4. Repeat the identical sample (11475) -> duty stays 132, dir=0, duty_valid pulses once.
5. Rising power while duty is 236 -> duty=240. The next rising sample clamps at 240 and dir flips to 0; sample_valid with sample_ready=0 is ignored.
6. Drop ena during SETTLE -> IDLE, sample_ready=0, duty held. Assert rst_n=0 mid-MULT -> duty=128 and dir=1 immediately. With MPPT_PWM_EN and duty=64, pwm_out is high 64 of every 256 cycles.
